// File: rtl/pe_pkg.sv
// Shared types and constants for the pe scheduler and its arbiter.
package pe_pkg;

    localparam int DATA_W   = 8;
    localparam int RES_W    = 9;
    localparam int OP_W     = 4;
    // Widest requester id the tag can carry (16 requesters).
    localparam int MAX_ID_W = 4;

    localparam logic [OP_W-1:0] OP_LEGAL_MAX = 4'd3;

    typedef enum logic [OP_W-1:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        MAC = 4'd3
    } op_t;

    // Payload of one requester. The opcode is kept as raw bits so that
    // illegal encodings can be carried through and flagged.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [OP_W-1:0]   op;
    } pe_req_t;

    // Tag that travels alongside an operation through the pipeline.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic                err;
    } pe_tag_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_LEGAL_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or
// after the rotating pointer; the pointer moves past the winner whenever
// the caller signals that the grant was taken.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    input  logic             advance
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   idx_wide;
    logic [ID_W-1:0] idx;
    logic            found;

    // Search from the pointer upward with wrap; first active request wins.
    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        found    = 1'b0;
        idx_wide = '0;
        idx      = '0;
        if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx_wide = {1'b0, ptr} + (ID_W + 1)'(k);
                if (idx_wide >= (ID_W + 1)'(N_REQ)) begin
                    idx_wide = idx_wide - (ID_W + 1)'(N_REQ);
                end
                idx = idx_wide[ID_W-1:0];
                if (!found && req[idx]) begin
                    found       = 1'b1;
                    gnt[idx]    = 1'b1;
                    gnt_id      = idx;
                end
            end
        end
    end

    // Pointer moves to the requester after the winner only when the grant was used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/pe_sched.sv
// Round-robin scheduler sharing one external pe between N_REQ requesters.
// Issue stage drives the pe pins one cycle after the handshake; the
// response stage returns the tagged result one cycle later.
module pe_sched
    import pe_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sched_en,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_a,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_b,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_c,
    input  logic [N_REQ-1:0][OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]            pe_a,
    output logic [DATA_W-1:0]            pe_b,
    output logic [DATA_W-1:0]            pe_c,
    output logic                         pe_en,
    output logic [OP_W-1:0]              pe_op,
    input  logic [RES_W-1:0]             pe_result,
    output logic                         resp_valid,
    output logic [ID_W-1:0]              resp_id,
    output logic [RES_W-1:0]             resp_result,
    output logic                         resp_err,
    output logic                         busy,
    output logic [CNT_W-1:0]             issue_cnt
);

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             handshake;
    pe_req_t          sel;
    pe_tag_t          st1_tag;

    // Grants are only ever given to valid requesters, so any grant is a handshake.
    assign req_ready = gnt;
    assign handshake = |gnt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sched_en),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .advance (handshake)
    );

    // Payload of the granted requester.
    always_comb begin
        sel = '{a: req_a[gnt_id], b: req_b[gnt_id], c: req_c[gnt_id], op: req_op[gnt_id]};
    end

    // Issue stage: load the pe pins on a handshake; operands hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_a    <= '0;
            pe_b    <= '0;
            pe_c    <= '0;
            pe_op   <= '0;
            pe_en   <= 1'b0;
            st1_tag <= '0;
        end else if (handshake) begin
            pe_a    <= sel.a;
            pe_b    <= sel.b;
            pe_c    <= sel.c;
            pe_op   <= sel.op;
            pe_en   <= op_is_legal(sel.op);
            st1_tag <= '{valid: 1'b1, id: MAX_ID_W'(gnt_id), err: ~op_is_legal(sel.op)};
        end else begin
            pe_en   <= 1'b0;
            st1_tag <= '0;
        end
    end

    // Response stage: the tag arrives together with the pe's registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= st1_tag.valid;
            resp_id    <= ID_W'(st1_tag.id);
            resp_err   <= st1_tag.valid & st1_tag.err;
        end
    end

    // Count every accepted operation, legal or not; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (handshake) begin
            issue_cnt <= issue_cnt + 1'b1;
        end
    end

    assign resp_result = (resp_valid && !resp_err) ? pe_result : '0;
    assign busy        = handshake | st1_tag.valid | resp_valid;

endmodule
